// File: rtl/tile_pkg.sv
// Shared widths, constants and types for the scrolling tile-map renderer.
package tile_pkg;

  localparam int unsigned DISPLAY_HEIGHT = 768;
  localparam int unsigned TILE_LOG2      = 5;
  localparam int unsigned MAP_COLS_LOG2  = 6;
  localparam int unsigned MAP_ROWS       = 24;
  localparam int unsigned WORLD_W_LOG2   = 11;

  localparam int unsigned HCOUNT_W    = 11;
  localparam int unsigned VCOUNT_W    = 10;
  localparam int unsigned SPEED_W     = 4;
  localparam int unsigned TILE_ID_W   = 8;
  localparam int unsigned MAP_ROW_W   = $clog2(MAP_ROWS);
  localparam int unsigned MAP_ADDR_W  = MAP_ROW_W + MAP_COLS_LOG2;
  localparam int unsigned TILE_ADDR_W = TILE_ID_W + 2 * TILE_LOG2;
  localparam int unsigned RGB_W       = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t TRANSPARENT = 12'hF0F;

  // Timing bundle carried alongside the pixel pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } timing_t;

endpackage

// File: rtl/tile_scroller_if.sv
// Tile-map and tile-pixel BRAM read bus.
//   map_addr_out  : tile-map address {row, col}
//   map_data_in   : tile id, one cycle after the address
//   tile_addr_out : tile-pixel address {tile_id, ty, tx}
//   tile_data_in  : RGB444 pixel, one cycle after the address
interface tile_scroller_if;
  import tile_pkg::*;

  logic [MAP_ADDR_W-1:0]  map_addr_out;
  logic [TILE_ID_W-1:0]   map_data_in;
  logic [TILE_ADDR_W-1:0] tile_addr_out;
  rgb_t                   tile_data_in;

  modport master (
    output map_addr_out,
    input  map_data_in,
    output tile_addr_out,
    input  tile_data_in
  );

  modport slave (
    input  map_addr_out,
    output map_data_in,
    input  tile_addr_out,
    output tile_data_in
  );

endinterface

// File: rtl/sync_delay.sv
// Fixed-depth shift register for the {hsync, vsync, blank} timing bundle.
//   clk_i : clock
//   rst_i : synchronous active-high reset; every stage loads all ones
//   d_i   : input word
//   q_o   : d_i delayed by DEPTH cycles
module sync_delay #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // All-ones reset keeps syncs inactive and the display blanked.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '1;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tile_scroller.sv
// Horizontally scrolling tile-map background stage behind the VGA timing generator.
//   vclock_in, reset_in            : pixel clock, synchronous active-high reset
//   hcount_in, vcount_in           : raster position
//   hsync_in, vsync_in, blank_in   : timing from the generator
//   scroll_speed_in, pause_in      : scroll control, used only at the frame boundary
//   bg_color_in                    : replaces TRANSPARENT tile pixels
//   mem                            : tile-map / tile-pixel BRAM bus
//   pixel_out, *sync_out, blank_out: rendered pixel and timing, 4 cycles after sampling
//   frame_tick_out, scroll_x_out   : per-frame pulse and current scroll offset
module tile_scroller
  import tile_pkg::*;
(
  input  logic                vclock_in,
  input  logic                reset_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                blank_in,
  input  logic [SPEED_W-1:0]  scroll_speed_in,
  input  logic                pause_in,
  input  rgb_t                bg_color_in,
  tile_scroller_if.master     mem,
  output rgb_t                pixel_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                blank_out,
  output logic                frame_tick_out,
  output logic [WORLD_W_LOG2-1:0] scroll_x_out
);

  // Input sample stage
  logic [HCOUNT_W-1:0]     h0_q;
  logic [VCOUNT_W-1:0]     v0_q;
  logic [SPEED_W-1:0]      speed0_q;
  logic                    pause0_q;
  timing_t                 tim0_q;
  // S1: world coordinates
  logic [WORLD_W_LOG2-1:0] wx1_q, wx1_d;
  logic [VCOUNT_W-1:0]     wy1_q;
  logic                    blank1_q;
  // S2: in-tile coordinates
  logic [TILE_LOG2-1:0]    tx2_q, ty2_q;
  logic                    blank2_q;
  // S3 / output
  logic                    blank3_q;
  rgb_t                    pixel_q, pixel_d;
  // Scroll state
  logic [WORLD_W_LOG2-1:0] scroll_q, scroll_d;
  logic                    tick_q, tick_d;
  timing_t                 tim4;

  // Next-state: world x wrap, frame-boundary scroll update, pixel select.
  always_comb begin
    scroll_d = scroll_q;
    tick_d   = 1'b0;
    pixel_d  = '0;
    // 12-bit sum truncated to 11 bits gives the modulo-2048 world wrap.
    wx1_d    = WORLD_W_LOG2'(12'(h0_q) + 12'(scroll_q));
    if (h0_q == '0 && v0_q == VCOUNT_W'(DISPLAY_HEIGHT)) begin
      tick_d = 1'b1;
      if (!pause0_q) scroll_d = scroll_q + WORLD_W_LOG2'(speed0_q);
    end
    if (!blank3_q) begin
      pixel_d = (mem.tile_data_in == TRANSPARENT) ? bg_color_in : mem.tile_data_in;
    end
  end

  // Pipeline and scroll registers; reset fills every stage with a blanked slot.
  always_ff @(posedge vclock_in) begin
    if (reset_in) begin
      h0_q     <= '0;
      v0_q     <= '0;
      speed0_q <= '0;
      pause0_q <= 1'b0;
      tim0_q   <= '1;
      wx1_q    <= '0;
      wy1_q    <= '0;
      blank1_q <= 1'b1;
      tx2_q    <= '0;
      ty2_q    <= '0;
      blank2_q <= 1'b1;
      blank3_q <= 1'b1;
      pixel_q  <= '0;
      scroll_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      h0_q     <= hcount_in;
      v0_q     <= vcount_in;
      speed0_q <= scroll_speed_in;
      pause0_q <= pause_in;
      tim0_q   <= '{hsync: hsync_in, vsync: vsync_in, blank: blank_in};
      wx1_q    <= wx1_d;
      wy1_q    <= v0_q;
      blank1_q <= tim0_q.blank;
      tx2_q    <= wx1_q[TILE_LOG2-1:0];
      ty2_q    <= wy1_q[TILE_LOG2-1:0];
      blank2_q <= blank1_q;
      blank3_q <= blank2_q;
      pixel_q  <= pixel_d;
      scroll_q <= scroll_d;
      tick_q   <= tick_d;
    end
  end

  // Blanked slots never address the BRAMs (keeps vblank rows 24+ off the map).
  assign mem.map_addr_out  = blank1_q ? '0
                           : {wy1_q[VCOUNT_W-1 -: MAP_ROW_W], wx1_q[WORLD_W_LOG2-1 -: MAP_COLS_LOG2]};
  assign mem.tile_addr_out = blank2_q ? '0 : {mem.map_data_in, ty2_q, tx2_q};

  sync_delay #(
    .DEPTH(4),
    .WIDTH(3)
  ) u_sync_delay (
    .clk_i(vclock_in),
    .rst_i(reset_in),
    .d_i  (tim0_q),
    .q_o  (tim4)
  );

  assign pixel_out      = pixel_q;
  assign hsync_out      = tim4.hsync;
  assign vsync_out      = tim4.vsync;
  assign blank_out      = tim4.blank;
  assign frame_tick_out = tick_q;
  assign scroll_x_out   = scroll_q;

endmodule

// File: tb/tb_tile_scroller.sv
// Scoreboard bench for tile_scroller: the driver queues expected responses
// stamped with the cycle they must appear; the monitor checks them there.
module tb_tile_scroller;
  import tile_pkg::*;

  localparam int K_PIPE  = 0;  // {pixel, hsync, vsync, blank}
  localparam int K_CTL   = 1;  // {frame_tick, scroll_x}
  localparam int K_MAP   = 2;  // map_addr_out
  localparam int K_TADDR = 3;  // tile_addr_out

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, blank_in;
  logic [3:0]  scroll_speed_in;
  logic        pause_in;
  rgb_t        bg_color_in;
  rgb_t        pixel_out;
  logic        hsync_out, vsync_out, blank_out, frame_tick_out;
  logic [10:0] scroll_x_out;

  tile_scroller_if mem_if ();

  tile_scroller u_dut (
    .vclock_in      (clk),
    .reset_in       (reset_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .blank_in       (blank_in),
    .scroll_speed_in(scroll_speed_in),
    .pause_in       (pause_in),
    .bg_color_in    (bg_color_in),
    .mem            (mem_if),
    .pixel_out      (pixel_out),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .blank_out      (blank_out),
    .frame_tick_out (frame_tick_out),
    .scroll_x_out   (scroll_x_out)
  );

  always #5 clk = ~clk;

  // BRAM models, one-cycle read latency
  logic [7:0]  map_mem [2048];
  logic [11:0] tile_mem [int];

  always @(posedge clk) begin
    mem_if.map_data_in  <= map_mem[mem_if.map_addr_out];
    mem_if.tile_data_in <= tile_mem.exists(int'(mem_if.tile_addr_out))
                           ? tile_mem[int'(mem_if.tile_addr_out)] : 12'h000;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_c = 0;
  logic [10:0] m_scroll = 11'd0;
  logic [3:0]  sp = 4'd0;
  logic        ps = 1'b0;

  function automatic void push(input int due, input int kind, input logic [31:0] val);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  // One input sample per cycle; queues the responses it must produce.
  task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic bl,
                       input logic hs, input logic vs, input rgb_t pix, input logic rst);
    int   c;
    logic tick;
    @(negedge clk);
    c               = cyc;
    last_c          = c;
    reset_in        = rst;
    hcount_in       = h;
    vcount_in       = v;
    blank_in        = bl;
    hsync_in        = hs;
    vsync_in        = vs;
    scroll_speed_in = sp;
    pause_in        = ps;
    if (rst) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].due > c) exp_q.delete(i);
      end
      for (int k = 1; k <= 5; k++) push(c + k, K_PIPE, 32'h7);
      push(c + 1, K_CTL, 32'h0);
      push(c + 2, K_CTL, 32'h0);
      push(c + 1, K_MAP, 32'h0);
      push(c + 1, K_TADDR, 32'h0);
      m_scroll = 11'd0;
    end else begin
      push(c + 5, K_PIPE, {17'd0, pix, hs, vs, bl});
      tick = (h == 11'd0) && (v == 10'd768);
      if (tick && !ps) m_scroll = m_scroll + 11'(sp);
      push(c + 2, K_CTL, {20'd0, tick, m_scroll});
    end
  endtask

  task automatic idle_vblank(input int n);
    for (int i = 0; i < n; i++) drive(11'(100 + i), 10'd770, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic boundary();
    drive(11'd0, 10'd768, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
  endtask

  // Monitor: compare every expectation at the cycle it falls due.
  always @(negedge clk) begin
    int          i;
    logic [31:0] got;
    string       nm;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].due <= cyc) begin
        case (exp_q[i].kind)
          K_PIPE:  begin got = {17'd0, pixel_out, hsync_out, vsync_out, blank_out}; nm = "pixel_sync"; end
          K_CTL:   begin got = {20'd0, frame_tick_out, scroll_x_out}; nm = "tick_scroll"; end
          K_MAP:   begin got = {21'd0, mem_if.map_addr_out}; nm = "map_addr"; end
          default: begin got = {14'd0, mem_if.tile_addr_out}; nm = "tile_addr"; end
        endcase
        n_cmp++;
        if (exp_q[i].due < cyc) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: expectation due at cyc %0d was never checked", nm, cyc, exp_q[i].due);
        end else if (got !== exp_q[i].val) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got %h, expected %h", nm, cyc, got, exp_q[i].val);
        end
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) map_mem[i] = 8'h00;
    reset_in = 1'b1; hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    scroll_speed_in = '0; pause_in = 1'b0; bg_color_in = 12'h00A;

    // Reset
    drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
    drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);

    // Free-running short lines against all-zero memories
    for (int n = 0; n < 300; n++) begin
      logic [10:0] h;
      logic [9:0]  v;
      h = 11'(n % 100);
      v = 10'(n / 100);
      drive(h, v, h >= 11'd80, !(h >= 11'd85 && h < 11'd90), !(v == 10'd2 && h < 11'd20),
            12'h000, 1'b0);
    end

    // Directed tile fetch: map(0,1)=5, tile 5 (ty0,tx3)=123, (ty0,tx4)=F0F
    map_mem[1]     = 8'h05;
    tile_mem[5123] = 12'h123;
    tile_mem[5124] = 12'hF0F;
    map_mem[64]    = 8'h09;
    tile_mem[9474] = 12'h7E1;
    drive(11'd35, 10'd0, 1'b0, 1'b1, 1'b1, 12'h123, 1'b0);
    push(last_c + 2, K_MAP, 32'd1);
    push(last_c + 3, K_TADDR, 32'd5123);
    drive(11'd36, 10'd0, 1'b0, 1'b1, 1'b1, 12'h00A, 1'b0);
    drive(11'd36, 10'd0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0);
    push(last_c + 2, K_MAP, 32'd0);
    push(last_c + 3, K_TADDR, 32'd0);
    idle_vblank(3);

    // Scroll speed 3 over three frames, then speed 7 set mid-frame
    sp = 4'd3;
    idle_vblank(3);
    boundary();
    push(last_c + 2, K_CTL, 32'h803);
    idle_vblank(3);
    drive(11'd32, 10'd0, 1'b0, 1'b1, 1'b1, 12'h123, 1'b0);
    drive(11'd33, 10'd0, 1'b0, 1'b1, 1'b1, 12'h00A, 1'b0);
    idle_vblank(3);
    boundary();
    push(last_c + 2, K_CTL, 32'h806);
    idle_vblank(3);
    boundary();
    push(last_c + 2, K_CTL, 32'h809);
    idle_vblank(3);
    sp = 4'd7;
    idle_vblank(4);
    push(last_c + 2, K_CTL, 32'd9);
    boundary();
    push(last_c + 2, K_CTL, 32'h810);
    idle_vblank(3);

    // Wrap: 255 frames at speed 8 reach 2040, the next one wraps to 0
    drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
    sp = 4'd8;
    for (int f = 0; f < 255; f++) begin
      boundary();
      drive(11'd1, 10'd768, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    end
    drive(11'd10, 10'd40, 1'b0, 1'b1, 1'b1, 12'h7E1, 1'b0);
    push(last_c + 2, K_CTL, 32'd2040);
    push(last_c + 2, K_MAP, 32'h040);
    push(last_c + 3, K_TADDR, 32'd9474);
    idle_vblank(3);
    boundary();
    push(last_c + 2, K_CTL, 32'h800);
    idle_vblank(3);

    // Pause holds the offset across a boundary
    sp = 4'd5;
    boundary();
    push(last_c + 2, K_CTL, 32'h805);
    idle_vblank(3);
    ps = 1'b1;
    idle_vblank(2);
    boundary();
    push(last_c + 2, K_CTL, 32'h805);
    idle_vblank(2);
    ps = 1'b0;
    idle_vblank(2);

    // Mid-line reset; outputs stay blanked with inactive syncs for 4 cycles
    drive(11'd498, 10'd10, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
    drive(11'd499, 10'd10, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
    drive(11'd500, 10'd10, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1);
    drive(11'd35, 10'd0, 1'b0, 1'b0, 1'b1, 12'h123, 1'b0);
    drive(11'd36, 10'd0, 1'b0, 1'b1, 1'b0, 12'h00A, 1'b0);
    idle_vblank(6);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations still pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
